// File: rtl/dmem_dump_reader.sv
// Debug-side data memory dumper: walks the data RAM word by word after a halt
// and streams each word MSB-first as bytes over a valid/ready link to the UART TX.
module dmem_dump_reader #(
    parameter int NB_WIDTH = 32,
    parameter int NB_ADDR  = 9,
    parameter int NB_DATA  = 8,
    parameter int N_WORDS  = 128
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_WIDTH-1:0] i_mem_data,
    input  logic                i_tx_ready,
    output logic [NB_ADDR-1:0]  o_mem_addr,
    output logic                o_mem_re,
    output logic [NB_DATA-1:0]  o_tx_data,
    output logic                o_tx_valid,
    output logic                o_busy,
    output logic                o_done
);

    localparam int NB_CNT = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [NB_CNT-1:0] LAST_WORD = NB_CNT'(N_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SEND,
        NEXT,
        DONE
    } state_t;

    state_t              state, state_next;
    logic [NB_CNT-1:0]   word_cnt, word_cnt_next;
    logic [1:0]          byte_idx, byte_idx_next;
    logic [NB_WIDTH-1:0] shift_reg, shift_next;
    logic [NB_ADDR-1:0]  mem_addr, mem_addr_next;
    logic                mem_re, mem_re_next;
    logic [NB_DATA-1:0]  tx_data, tx_data_next;
    logic                tx_valid, tx_valid_next;
    logic                busy, busy_next;
    logic                done, done_next;

    // Every output comes straight from a register, so the RAM mux and TX see clean timing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            byte_idx  <= '0;
            shift_reg <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            word_cnt  <= word_cnt_next;
            byte_idx  <= byte_idx_next;
            shift_reg <= shift_next;
            mem_addr  <= mem_addr_next;
            mem_re    <= mem_re_next;
            tx_data   <= tx_data_next;
            tx_valid  <= tx_valid_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        byte_idx_next = byte_idx;
        shift_next    = shift_reg;
        mem_addr_next = mem_addr;
        mem_re_next   = mem_re;
        tx_data_next  = tx_data;
        tx_valid_next = tx_valid;
        busy_next     = busy;
        done_next     = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next    = LATCH;
                    word_cnt_next = '0;
                    mem_addr_next = '0;
                    busy_next     = 1'b1;
                    mem_re_next   = 1'b1;
                end
            end
            LATCH: begin
                shift_next    = i_mem_data;
                byte_idx_next = '0;
                tx_valid_next = 1'b1;
                tx_data_next  = i_mem_data[NB_WIDTH-1 -: NB_DATA];
                state_next    = SEND;
            end
            SEND: begin
                // The top byte of shift_reg is always the one on the wire.
                if (tx_valid && i_tx_ready) begin
                    if (byte_idx == 2'd3) begin
                        tx_valid_next = 1'b0;
                        state_next    = NEXT;
                    end else begin
                        byte_idx_next = byte_idx + 2'd1;
                        shift_next    = shift_reg << NB_DATA;
                        tx_data_next  = shift_reg[NB_WIDTH-NB_DATA-1 -: NB_DATA];
                    end
                end
            end
            NEXT: begin
                if (word_cnt == LAST_WORD) begin
                    state_next = DONE;
                end else begin
                    word_cnt_next = word_cnt + NB_CNT'(1);
                    mem_addr_next = mem_addr + NB_ADDR'(4);
                    state_next    = LATCH;
                end
            end
            DONE: begin
                done_next   = 1'b1;
                busy_next   = 1'b0;
                mem_re_next = 1'b0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_mem_addr = mem_addr;
    assign o_mem_re   = mem_re;
    assign o_tx_data  = tx_data;
    assign o_tx_valid = tx_valid;
    assign o_busy     = busy;
    assign o_done     = done;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Scoreboard bench for dmem_dump_reader: a short 2-word instance for protocol cases
// and a full 128-word instance for the whole-memory sweep.
module tb_dmem_dump_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0, ready_a = 1'b1;
    logic [31:0] mem_data_a;
    logic [8:0]  addr_a;
    logic        re_a, valid_a, busy_a, done_a;
    logic [7:0]  tx_a;

    logic        start_b = 1'b0, ready_b = 1'b1;
    logic [31:0] mem_data_b;
    logic [8:0]  addr_b;
    logic        re_b, valid_b, busy_b, done_b;
    logic [7:0]  tx_b;

    logic [31:0] mem_a [0:127];
    logic [31:0] mem_b [0:127];
    logic        ovr_a = 1'b0;
    logic [31:0] ovr_val = 32'h0;

    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic        hold_a = 1'b0;
    logic [7:0]  hold_byte_a = 8'h0;
    int          xfer_b = 0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mem_data_a = ovr_a ? ovr_val : mem_a[addr_a[8:2]];
    assign mem_data_b = mem_b[addr_b[8:2]];

    dmem_dump_reader #(.NB_WIDTH(32), .NB_ADDR(9), .NB_DATA(8), .N_WORDS(2)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_start(start_a), .i_mem_data(mem_data_a),
        .i_tx_ready(ready_a), .o_mem_addr(addr_a), .o_mem_re(re_a), .o_tx_data(tx_a),
        .o_tx_valid(valid_a), .o_busy(busy_a), .o_done(done_a)
    );

    dmem_dump_reader #(.NB_WIDTH(32), .NB_ADDR(9), .NB_DATA(8), .N_WORDS(128)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_mem_data(mem_data_b),
        .i_tx_ready(ready_b), .o_mem_addr(addr_b), .o_mem_re(re_b), .o_tx_data(tx_b),
        .o_tx_valid(valid_b), .o_busy(busy_b), .o_done(done_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: on the falling edge, valid && ready means a transfer at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (hold_a) begin
                checkOutput("a_stall_valid", {31'b0, valid_a}, 32'd1);
                checkOutput("a_stall_data", {24'b0, tx_a}, {24'b0, hold_byte_a});
            end
            if (valid_a && ready_a) begin
                if (exp_a.size() == 0) checkOutput("a_unexpected_byte", {24'b0, tx_a}, 32'hFFFF_FFFF);
                else checkOutput("a_byte", {24'b0, tx_a}, {24'b0, exp_a.pop_front()});
            end
            hold_a      = valid_a && !ready_a;
            hold_byte_a = tx_a;
            if (valid_b && ready_b) begin
                checkOutput("b_addr", {23'b0, addr_b}, (xfer_b / 4) * 4);
                if (exp_b.size() == 0) checkOutput("b_unexpected_byte", {24'b0, tx_b}, 32'hFFFF_FFFF);
                else checkOutput("b_byte", {24'b0, tx_b}, {24'b0, exp_b.pop_front()});
                xfer_b++;
            end
        end else begin
            hold_a = 1'b0;
        end
    end

    task automatic pushWord(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_a.push_back(w[i*8 +: 8]);
    endtask

    // Called #1 after a rising edge; returns #1 after the start edge.
    task automatic applyStimulus();
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    task automatic waitDone(input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            @(posedge clk);
            #1 cyc++;
            if (done_a) return;
        end
        cyc = -1;
    endtask

    initial begin
        int cyc;
        int dones;
        logic [3:0] pat;

        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = i;
        end
        mem_a[0] = 32'h11223344;
        mem_a[1] = 32'hAABBCCDD;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_addr", {23'b0, addr_a}, 32'd0);
        checkOutput("rst_re", {31'b0, re_a}, 32'd0);
        checkOutput("rst_data", {24'b0, tx_a}, 32'd0);
        checkOutput("rst_valid", {31'b0, valid_a}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy_a}, 32'd0);
        checkOutput("rst_done", {31'b0, done_a}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic two-word dump");
        pushWord(32'h11223344);
        pushWord(32'hAABBCCDD);
        applyStimulus();
        checkOutput("t1_busy", {31'b0, busy_a}, 32'd1);
        checkOutput("t1_re", {31'b0, re_a}, 32'd1);
        waitDone(100, cyc);
        checkOutput("t1_done_cycle", cyc, 32'd13);
        checkOutput("t1_busy_after", {31'b0, busy_a}, 32'd0);
        checkOutput("t1_queue_empty", exp_a.size(), 32'd0);

        $display("[TB] backpressure 1-0-0-1");
        mem_a[0] = 32'h12345678;
        mem_a[1] = 32'h9ABCDEF0;
        pushWord(32'h12345678);
        pushWord(32'h9ABCDEF0);
        pat = 4'b1001;
        applyStimulus();
        cyc = -1;
        for (int c = 0; c < 200; c++) begin
            ready_a = pat[c % 4];
            @(posedge clk);
            #1;
            if (done_a) begin
                cyc = c;
                break;
            end
        end
        ready_a = 1'b1;
        checkOutput("t2_done_seen", {31'b0, (cyc >= 0)}, 32'd1);
        checkOutput("t2_queue_empty", exp_a.size(), 32'd0);

        $display("[TB] reset mid-run");
        mem_a[0] = 32'h11223344;
        mem_a[1] = 32'hAABBCCDD;
        exp_a.push_back(8'h11);
        exp_a.push_back(8'h22);
        exp_a.push_back(8'h33);
        applyStimulus();
        repeat (4) @(posedge clk);
        #1;
        reset   = 1'b1;
        ready_a = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t3_valid", {31'b0, valid_a}, 32'd0);
        checkOutput("t3_busy", {31'b0, busy_a}, 32'd0);
        checkOutput("t3_addr", {23'b0, addr_a}, 32'd0);
        reset   = 1'b0;
        ready_a = 1'b1;
        checkOutput("t3_queue_empty", exp_a.size(), 32'd0);
        @(posedge clk);
        #1;
        pushWord(32'h11223344);
        pushWord(32'hAABBCCDD);
        applyStimulus();
        waitDone(100, cyc);
        checkOutput("t3_restart_done_cycle", cyc, 32'd13);
        checkOutput("t3_restart_queue_empty", exp_a.size(), 32'd0);

        $display("[TB] extra start pulses while busy");
        pushWord(32'h11223344);
        pushWord(32'hAABBCCDD);
        applyStimulus();
        dones = 0;
        for (int c = 1; c <= 40; c++) begin
            start_a = (c == 3 || c == 7 || c == 13);
            @(posedge clk);
            #1;
            if (done_a) dones++;
        end
        start_a = 1'b0;
        checkOutput("t4_done_count", dones, 32'd1);
        checkOutput("t4_busy_idle", {31'b0, busy_a}, 32'd0);
        checkOutput("t4_queue_empty", exp_a.size(), 32'd0);

        $display("[TB] memory data changes after latch");
        mem_a[0] = 32'h55667788;
        mem_a[1] = 32'h01020304;
        pushWord(32'h55667788);
        pushWord(32'h01020304);
        applyStimulus();
        @(posedge clk);
        #1;
        ovr_val = 32'hDEADBEEF;
        ovr_a   = 1'b1;
        repeat (4) @(posedge clk);
        #1 ovr_a = 1'b0;
        waitDone(100, cyc);
        checkOutput("t6_done_seen", {31'b0, (cyc >= 0)}, 32'd1);
        checkOutput("t6_queue_empty", exp_a.size(), 32'd0);

        $display("[TB] full memory sweep");
        for (int i = 0; i < 128; i++) begin
            exp_b.push_back(8'h00);
            exp_b.push_back(8'h00);
            exp_b.push_back(8'h00);
            exp_b.push_back(8'(i));
        end
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1;
            if (done_b) begin
                cyc = c;
                break;
            end
        end
        checkOutput("t5_done_cycle", cyc, 32'd769);
        checkOutput("t5_transfers", xfer_b, 32'd512);
        checkOutput("t5_queue_empty", exp_b.size(), 32'd0);
        checkOutput("t5_final_addr", {23'b0, addr_b}, 32'd508);
        checkOutput("t5_busy_after", {31'b0, busy_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
